// File: rtl/sync_fifo_thresh_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_pkg
//  Description : Shared types and elaboration helpers for the threshold FIFO
//                (address width, read-mode enum, parameter legality check).
//  Revision    : 1.0 - initial release
// ============================================================================
package sync_fifo_pkg;

    // Read-port behaviour of the FIFO
    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    // Pointer width for a given number of entries
    function automatic int fifo_aw(input int depth);
        return $clog2(depth);
    endfunction

    // True when the parameter set describes a buildable FIFO
    function automatic bit fifo_params_ok(
        input int width,
        input int depth,
        input int fwft,
        input int afull_lvl,
        input int aempty_lvl
    );
        bit ok;
        ok = (width >= 1);
        ok = ok && (depth >= 2) && (depth <= 256);
        ok = ok && ((depth & (depth - 1)) == 0);
        ok = ok && ((fwft == 0) || (fwft == 1));
        ok = ok && (afull_lvl >= 1) && (afull_lvl <= depth);
        ok = ok && (aempty_lvl >= 0) && (aempty_lvl <= depth - 1);
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_thresh_ram.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_lutram_sdp
//  Description : Simple dual-port distributed RAM, synchronous write port and
//                asynchronous read port. Contents start at zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_lutram_sdp
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                       i_clk,
    input  logic                       i_we,
    input  logic [fifo_aw(DEPTH)-1:0]  i_waddr,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic [fifo_aw(DEPTH)-1:0]  i_raddr,
    output logic [WIDTH-1:0]           o_rdata
);

    (* ram_style = "distributed" *)
    logic [WIDTH-1:0] r_mem [DEPTH] = '{default: '0};

    // Synchronous write port
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Asynchronous read: returns the contents as of the last clock edge
    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/sync_fifo_thresh.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_thresh
//  Description : Single-clock FIFO with almost-full/almost-empty thresholds,
//                occupancy output, registered error pulses and a selectable
//                standard or first-word-fall-through read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_thresh
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 16,
    parameter int FWFT       = 0,
    parameter int AFULL_LVL  = DEPTH - 2,
    parameter int AEMPTY_LVL = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_wren,
    output logic                       o_full,
    output logic                       o_afull,
    output logic                       o_werr,
    input  logic                       i_rden,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_valid,
    output logic                       o_empty,
    output logic                       o_aempty,
    output logic                       o_rerr,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int c_AW = fifo_aw(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam fifo_mode_e c_MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

    localparam logic [c_CW-1:0] c_DEPTH   = c_CW'(DEPTH);
    localparam logic [c_CW-1:0] c_AFULL   = c_CW'(AFULL_LVL);
    localparam logic [c_CW-1:0] c_AEMPTY  = c_CW'(AEMPTY_LVL);
    localparam logic [c_CW-1:0] c_CNT_ONE = c_CW'(1);
    localparam logic [c_AW-1:0] c_PTR_ONE = c_AW'(1);

    // Refuse to elaborate an unbuildable configuration
    if (!fifo_params_ok(WIDTH, DEPTH, FWFT, AFULL_LVL, AEMPTY_LVL)) begin : g_param_err
        $error("sync_fifo_thresh: illegal WIDTH/DEPTH/FWFT/AFULL_LVL/AEMPTY_LVL");
    end

    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic             r_werr;
    logic             r_rerr;
    logic             w_full;
    logic             w_empty;
    logic             w_rd_ok;
    logic             w_wr_ok;
    logic [WIDTH-1:0] w_ram_rdata;

    // Flags come straight from the registered occupancy, so they cannot glitch
    assign w_full  = (r_count == c_DEPTH);
    assign w_empty = (r_count == '0);

    // A write into a full FIFO is fine when a read frees the slot this cycle
    assign w_rd_ok = i_rden && !w_empty;
    assign w_wr_ok = i_wren && (!w_full || w_rd_ok);

    fifo_lutram_sdp #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_wr_ok),
        .i_waddr (r_wr_ptr),
        .i_wdata (i_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_ram_rdata)
    );

    // Pointer advance; pointers wrap naturally at DEPTH
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
        end
    end

    // Occupancy counter: simultaneous push and pop leave it unchanged
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else begin
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Error pulses for requests that were refused in the previous cycle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_werr <= 1'b0;
            r_rerr <= 1'b0;
        end else begin
            r_werr <= i_wren && !w_wr_ok;
            r_rerr <= i_rden && !w_rd_ok;
        end
    end

    if (c_MODE == FIFO_FWFT) begin : g_fwft
        // Head of the queue is visible without a read request
        assign o_data  = w_ram_rdata;
        assign o_valid = !w_empty;
    end else begin : g_std
        logic [WIDTH-1:0] r_dout;
        logic             r_valid;

        // Registered read stage; data holds when no read is accepted
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_dout  <= '0;
                r_valid <= 1'b0;
            end else begin
                r_valid <= w_rd_ok;
                if (w_rd_ok) begin
                    r_dout <= w_ram_rdata;
                end
            end
        end

        assign o_data  = r_dout;
        assign o_valid = r_valid;
    end

    assign o_full   = w_full;
    assign o_empty  = w_empty;
    assign o_afull  = (r_count >= c_AFULL);
    assign o_aempty = (r_count <= c_AEMPTY);
    assign o_count  = r_count;
    assign o_werr   = r_werr;
    assign o_rerr   = r_rerr;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_thresh.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sync_fifo_thresh
//  Description : Self-checking bench for sync_fifo_thresh. A standard-mode and
//                an FWFT-mode instance share one stimulus stream and are both
//                compared every cycle against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_thresh;

    localparam int c_W  = 16;
    localparam int c_D  = 16;
    localparam int c_AF = 14;
    localparam int c_AE = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [c_W-1:0]  din;
    logic            wren;
    logic            rden;

    logic            s_full, s_afull, s_werr, s_valid, s_empty, s_aempty, s_rerr;
    logic [c_W-1:0]  s_data;
    logic [4:0]      s_count;
    logic            f_full, f_afull, f_werr, f_valid, f_empty, f_aempty, f_rerr;
    logic [c_W-1:0]  f_data;
    logic [4:0]      f_count;

    // Reference model state
    logic [c_W-1:0]  mq[$];
    logic            m_valid;
    logic [c_W-1:0]  m_dout;
    logic            m_werr;
    logic            m_rerr;
    bit              chk_en = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sync_fifo_thresh #(
        .WIDTH(c_W), .DEPTH(c_D), .FWFT(0), .AFULL_LVL(c_AF), .AEMPTY_LVL(c_AE)
    ) u_std (
        .i_clk(clk), .i_rst(rst), .i_data(din), .i_wren(wren),
        .o_full(s_full), .o_afull(s_afull), .o_werr(s_werr),
        .i_rden(rden), .o_data(s_data), .o_valid(s_valid),
        .o_empty(s_empty), .o_aempty(s_aempty), .o_rerr(s_rerr), .o_count(s_count)
    );

    sync_fifo_thresh #(
        .WIDTH(c_W), .DEPTH(c_D), .FWFT(1), .AFULL_LVL(c_AF), .AEMPTY_LVL(c_AE)
    ) u_fwft (
        .i_clk(clk), .i_rst(rst), .i_data(din), .i_wren(wren),
        .o_full(f_full), .o_afull(f_afull), .o_werr(f_werr),
        .i_rden(rden), .o_data(f_data), .o_valid(f_valid),
        .o_empty(f_empty), .o_aempty(f_aempty), .o_rerr(f_rerr), .o_count(f_count)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference behaviour for one clock edge with the given request inputs
    task automatic model_update(input logic wr, input logic rd, input logic [c_W-1:0] d,
                                input logic r);
        bit rok;
        bit wok;
        if (r) begin
            mq.delete();
            m_valid = 1'b0;
            m_dout  = '0;
            m_werr  = 1'b0;
            m_rerr  = 1'b0;
        end else begin
            rok     = rd && (mq.size() != 0);
            wok     = wr && ((mq.size() < c_D) || rok);
            m_rerr  = rd && !rok;
            m_werr  = wr && !wok;
            m_valid = rok;
            if (rok) m_dout = mq.pop_front();
            if (wok) mq.push_back(d);
        end
    endtask

    // Apply requests for one cycle, then advance the model past that edge
    task automatic step(input logic wr, input logic rd, input logic [c_W-1:0] d);
        wren = wr;
        rden = rd;
        din  = d;
        @(posedge clk);
        #2;
        model_update(wr, rd, d, rst);
    endtask

    task automatic do_reset(input logic wr, input logic rd);
        rst = 1'b1;
        step(wr, rd, 16'h7777);
        rst = 1'b0;
    endtask

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("std_count",  32'(s_count),  32'(mq.size()));
            chk("std_full",   32'(s_full),   32'(mq.size() == c_D));
            chk("std_empty",  32'(s_empty),  32'(mq.size() == 0));
            chk("std_afull",  32'(s_afull),  32'(mq.size() >= c_AF));
            chk("std_aempty", 32'(s_aempty), 32'(mq.size() <= c_AE));
            chk("std_werr",   32'(s_werr),   32'(m_werr));
            chk("std_rerr",   32'(s_rerr),   32'(m_rerr));
            chk("std_valid",  32'(s_valid),  32'(m_valid));
            chk("std_data",   32'(s_data),   32'(m_dout));
            chk("fw_count",   32'(f_count),  32'(mq.size()));
            chk("fw_full",    32'(f_full),   32'(mq.size() == c_D));
            chk("fw_empty",   32'(f_empty),  32'(mq.size() == 0));
            chk("fw_afull",   32'(f_afull),  32'(mq.size() >= c_AF));
            chk("fw_aempty",  32'(f_aempty), 32'(mq.size() <= c_AE));
            chk("fw_werr",    32'(f_werr),   32'(m_werr));
            chk("fw_rerr",    32'(f_rerr),   32'(m_rerr));
            chk("fw_valid",   32'(f_valid),  32'(mq.size() != 0));
            if (mq.size() != 0) chk("fw_data", 32'(f_data), 32'(mq[0]));
        end
    end

    initial begin
        int pw;
        int pr;
        rst  = 1'b0;
        wren = 1'b0;
        rden = 1'b0;
        din  = '0;
        @(posedge clk);
        #2;

        // Reset with requests active: they must be ignored
        do_reset(1'b1, 1'b1);
        chk_en = 1'b1;
        chk("lit_rst_count",  32'(s_count),  32'd0);
        chk("lit_rst_empty",  32'(s_empty),  32'd1);
        chk("lit_rst_aempty", 32'(s_aempty), 32'd1);
        chk("lit_rst_full",   32'(s_full),   32'd0);
        chk("lit_rst_afull",  32'(s_afull),  32'd0);
        chk("lit_rst_errs",   32'({s_werr, s_rerr}), 32'd0);
        chk("lit_rst_valid",  32'(s_valid),  32'd0);
        chk("lit_rst_data",   32'(s_data),   32'd0);

        // Fill 0x0000..0x000F, watching threshold edges
        for (int i = 0; i < c_D; i++) begin
            step(1'b1, 1'b0, 16'(i));
            if (i == 1)  chk("lit_aempty_at2", 32'(s_aempty), 32'd1);
            if (i == 2)  chk("lit_aempty_at3", 32'(s_aempty), 32'd0);
            if (i == 12) chk("lit_afull_at13", 32'(s_afull),  32'd0);
            if (i == 13) chk("lit_afull_at14", 32'(s_afull),  32'd1);
        end
        chk("lit_fill_full",  32'(s_full),  32'd1);
        chk("lit_fill_count", 32'(s_count), 32'd16);

        // Overflow
        step(1'b1, 1'b0, 16'hDEAD);
        chk("lit_ovf_werr",  32'(s_werr),  32'd1);
        chk("lit_ovf_count", 32'(s_count), 32'd16);
        step(1'b0, 1'b0, 16'h0);
        chk("lit_ovf_werr_clr", 32'(s_werr), 32'd0);

        // Read and write together while full
        step(1'b1, 1'b1, 16'hAAAA);
        chk("lit_fullrw_data",  32'(s_data),  32'h0000);
        chk("lit_fullrw_valid", 32'(s_valid), 32'd1);
        chk("lit_fullrw_count", 32'(s_count), 32'd16);
        chk("lit_fullrw_werr",  32'(s_werr),  32'd0);
        chk("lit_fullrw_head",  32'(f_data),  32'h0001);

        // Drain: 0x0001..0x000F then the word written while full
        for (int i = 0; i < c_D; i++) begin
            step(1'b0, 1'b1, 16'h0);
            chk("lit_drain_data", 32'(s_data), (i < 15) ? 32'(i + 1) : 32'hAAAA);
        end
        chk("lit_drain_empty", 32'(s_empty), 32'd1);
        chk("lit_drain_count", 32'(s_count), 32'd0);

        // Underflow
        step(1'b0, 1'b1, 16'h0);
        chk("lit_udf_rerr",  32'(s_rerr),  32'd1);
        chk("lit_udf_valid", 32'(s_valid), 32'd0);

        // Read and write together while empty
        step(1'b1, 1'b1, 16'h1234);
        chk("lit_emptyrw_rerr",  32'(s_rerr),  32'd1);
        chk("lit_emptyrw_count", 32'(s_count), 32'd1);
        chk("lit_fwft_empty",    32'(f_empty), 32'd0);
        chk("lit_fwft_head",     32'(f_data),  32'h1234);
        step(1'b0, 1'b0, 16'h0);
        chk("lit_rerr_clr", 32'(s_rerr), 32'd0);
        step(1'b0, 1'b1, 16'h0);
        chk("lit_pop_data", 32'(s_data), 32'h1234);

        // Random traffic in write-heavy, balanced and read-heavy phases
        for (int ph = 0; ph < 6; ph++) begin
            pw = (ph % 3 == 0) ? 85 : (ph % 3 == 1) ? 50 : 20;
            pr = (ph % 3 == 0) ? 25 : (ph % 3 == 1) ? 50 : 85;
            for (int n = 0; n < 80; n++) begin
                step(($urandom_range(99) < pw), ($urandom_range(99) < pr),
                     16'($urandom));
            end
        end

        // Reset in the middle of traffic at occupancy 9
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 16'(16'h0100 + i));
        chk("lit_mid_count9", 32'(s_count), 32'd9);
        do_reset(1'b1, 1'b1);
        chk("lit_mid_count",  32'(s_count), 32'd0);
        chk("lit_mid_empty",  32'(s_empty), 32'd1);
        chk("lit_mid_errs",   32'({s_werr, s_rerr, f_werr, f_rerr}), 32'd0);
        step(1'b1, 1'b0, 16'h0BEE);
        chk("lit_mid_fwft",   32'(f_data),  32'h0BEE);
        step(1'b0, 1'b1, 16'h0);
        chk("lit_mid_data",   32'(s_data),  32'h0BEE);
        step(1'b0, 1'b0, 16'h0);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sync_fifo_thresh.md
Name: sync_fifo_thresh

Overview:
Parametrised single-clock FIFO that succeeds the basic LUTRAM FIFO.
- Adds programmable almost-full and almost-empty thresholds, an exported occupancy count and registered error pulses.
- Supports simultaneous read and write at any fill level, including full and empty.
- Offers a selectable first-word-fall-through (FWFT) read mode.
- Sits between streaming producers and consumers in the same clock domain, such as ADC capture to packetiser or UART RX to command parser.

Parameters:
- WIDTH, 16, data word width in bits; must be ≥1.
- DEPTH, 16, number of entries; must be a power of two with 2 ≤ DEPTH ≤ 256; elaboration error otherwise.
- FWFT, 0, read mode: 0 = standard (registered) read, 1 = first-word-fall-through.
- AFULL_LVL, DEPTH-2, o_afull asserts when occupancy ≥ AFULL_LVL; range 1..DEPTH.
- AEMPTY_LVL, 2, o_aempty asserts when occupancy ≤ AEMPTY_LVL; range 0..DEPTH-1.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_data  in  WIDTH  write data.
- i_wren  in  1  write request.
- o_full  out  1  occupancy == DEPTH.
- o_afull  out  1  occupancy ≥ AFULL_LVL.
- o_werr  out  1  one-cycle pulse: write rejected in the previous cycle.
- i_rden  in  1  read request (in FWFT mode, a pop/acknowledge).
- o_data  out  WIDTH  read data.
- o_valid  out  1  standard mode: o_data updated this cycle; FWFT mode: equals !o_empty.
- o_empty  out  1  occupancy == 0.
- o_aempty  out  1  occupancy ≤ AEMPTY_LVL.
- o_rerr  out  1  one-cycle pulse: read rejected in the previous cycle.
- o_count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Pointers: wr_ptr and rd_ptr are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0. Occupancy is a separate registered counter with $clog2(DEPTH)+1 bits.
- Read accept: rd_ok = i_rden && !o_empty.
- Write accept: wr_ok = i_wren && (!o_full || rd_ok). A write to a full FIFO is accepted when a read is accepted in the same cycle.
- Occupancy update, per cycle:
  - wr_ok only: +1.
  - rd_ok only: -1.
  - both, or neither: unchanged.
  - Occupancy never exceeds DEPTH and never underflows.
- RAM write happens only on wr_ok. A rejected write must not corrupt any entry.
- Standard mode (FWFT=0):
  - On rd_ok, o_data <= ram[rd_ptr] and o_valid = 1 on the next cycle; otherwise o_valid = 0.
  - o_data holds its last value when no read is accepted.
  - Latency from write to readable: 1 cycle (o_empty deasserts the cycle after wr_ok). Latency from read to data: 1 cycle.
- FWFT mode (FWFT=1):
  - o_data = ram[rd_ptr] combinationally (distributed RAM async read) and is valid whenever !o_empty.
  - i_rden pops the head, and the next entry appears in the following cycle.
- Simultaneous read and write when empty: the write is accepted and the read is rejected (o_rerr pulses). Occupancy becomes 1.
- Simultaneous read and write when full: both are accepted, and occupancy stays DEPTH. Read data is the oldest entry, never the word being written.
- Error pulses:
  - o_werr is registered: 1 for one cycle after i_wren && !wr_ok.
  - o_rerr is registered: 1 for one cycle after i_rden && !rd_ok.
  - Back-to-back rejections give continuous assertion.
- Flags: o_full, o_empty, o_afull, o_aempty and o_count are all derived from registered occupancy. They are glitch-free and reflect state after the last clock edge.
- Reset (i_rst=1 at a clock edge), including mid-transfer:
  - Pointers = 0, occupancy = 0.
  - o_empty = 1, o_aempty = 1, o_full = 0.
  - o_afull = 0, or 1 only if AFULL_LVL == 0, which is illegal.
  - o_werr = o_rerr = 0, o_valid = 0, o_data = 0 (standard mode).
  - Requests during reset are ignored and generate no errors.
  - RAM contents are not reset; only the pointers make the contents unreachable.
- RAM is initialised to 0 at configuration.

Decomposition:
- Package sync_fifo_pkg:
  - function fifo_aw(depth) returning $clog2(depth).
  - fifo_mode_e enum {FIFO_STD=0, FIFO_FWFT=1}.
  - Parameter-legality check function used in elaboration assertions.
- Sub-module fifo_lutram_sdp: simple dual-port distributed RAM.
  - Write port is synchronous.
  - Read port is asynchronous.
  - Parameters WIDTH and DEPTH; RAM_STYLE="distributed" attribute; initialised to 0.
  - The top level adds the registered read stage in standard mode.

Test Plan:
- Fill and drain (DEPTH=16, FWFT=0): write 0x0000..0x000F, then read 16 times → o_full=1 after the 16th write; reads return 0x0000..0x000F in order, each 1 cycle after i_rden; o_empty=1 after the last read; o_count goes 16→0.
- Overflow and underflow: 17th write while full → o_werr pulses 1 cycle, o_count stays 16, and the first read still returns 0x0000. Read when empty → o_rerr pulses, o_valid=0.
- Simultaneous read and write: at full, write 0xAAAA with a concurrent read → read returns the oldest word, o_count stays 16, o_werr=0. At empty, read plus write → o_rerr=1 and o_count=1.
- Thresholds (AFULL_LVL=14, AEMPTY_LVL=2): step occupancy 0→16→0 → o_aempty=1 for counts 0..2; o_afull=1 for counts 14..16; all transitions are 1 cycle after the causing edge.
- FWFT (FWFT=1): write 0x1234 into an empty FIFO → next cycle o_empty=0 and o_data=0x1234 with no i_rden. Pop → next head is shown; wrap-around is verified over 3×DEPTH random pushes and pops against a scoreboard.
- Reset mid-operation: at occupancy 9, assert i_rst for 1 cycle with i_wren=i_rden=1 → o_count=0, o_empty=1, no error pulses. The first subsequent write and read returns the new data.
